stepper_scheduler: RTL and testbench

- Sequences the two stepper drivers downstream of the SCARA kinematic controller.
- Accepts one coordinated move per handshake: a step count and direction per joint.
- Emits step/dir pin waveforms with Bresenham interpolation, so both joints start and finish together.
- Sits between the controller's `m1_steps`/`m2_steps`/`dir1`/`dir2`/`controller_ready` outputs and the motor-driver pins, and drives the controller's `stepper_ready` input.

---
 rtl/scara_pkg.sv | 16 +
 rtl/step_slot_timer.sv | 44 ++++
 rtl/stepper_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_stepper_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scara_pkg.sv
// Shared types and default timing constants for the SCARA stepper path.
package scara_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SLOT,
        DONE
    } sched_state_t;

    localparam int STEP_W_DEF      = 64;
    localparam int STEP_PERIOD_DEF = 1000;
    localparam int PULSE_W_DEF     = 100;
    localparam int DIR_SETUP_DEF   = 50;

endpackage

// File: rtl/step_slot_timer.sv
// In-slot cycle counter. Its flags describe the position the counter takes on
// the next edge, so the scheduler can register its pins without a cycle of lag.
module step_slot_timer
    import scara_pkg::*;
#(
    parameter int STEP_PERIOD = STEP_PERIOD_DEF,
    parameter int PULSE_W     = PULSE_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic slot_start,
    output logic pulse_active,
    output logic slot_end
);

    localparam int CW = $clog2(STEP_PERIOD);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clear) begin
            w_cnt_nxt = '0;
        end else if (en) begin
            w_cnt_nxt = (r_cnt == CW'(STEP_PERIOD - 1)) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign slot_start   = (w_cnt_nxt == '0);
    assign pulse_active = (w_cnt_nxt < CW'(PULSE_W));
    assign slot_end     = (w_cnt_nxt == CW'(STEP_PERIOD - 1));

endmodule

// File: rtl/stepper_scheduler.sv
// Two-joint step/dir sequencer: accepts one coordinated move and spreads the
// minor-axis steps across the major-axis slots with a Bresenham accumulator.
module stepper_scheduler
    import scara_pkg::*;
#(
    parameter int STEP_W      = STEP_W_DEF,
    parameter int STEP_PERIOD = STEP_PERIOD_DEF,
    parameter int PULSE_W     = PULSE_W_DEF,
    parameter int DIR_SETUP   = DIR_SETUP_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [STEP_W-1:0] m1_steps,
    input  logic [STEP_W-1:0] m2_steps,
    input  logic              dir1_in,
    input  logic              dir2_in,
    input  logic              abort,
    output logic              stepper_ready,
    output logic              step1,
    output logic              step2,
    output logic              dir1,
    output logic              dir2,
    output logic              move_done
);

    localparam int SW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;

    logic [SW-1:0]     r_setup_cnt;
    logic [STEP_W-1:0] r_n;
    logic [STEP_W-1:0] r_m;
    logic [STEP_W-1:0] r_err;
    logic [STEP_W-1:0] r_slots_done;
    logic              r_maj1;
    logic              r_fire1;
    logic              r_fire2;
    logic              r_step1;
    logic              r_step2;
    logic              r_dir1;
    logic              r_dir2;
    logic              r_done;
    logic              r_ready;

    logic              w_accept;
    logic              w_zero;
    logic              w_m1_ge;
    logic              w_setup_last;
    logic              w_last_slot;
    logic              w_slot_nxt;
    logic              w_new_slot;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_slot_start;
    logic              w_pulse_active;
    logic              w_slot_end;
    logic [STEP_W:0]   w_e_sum;
    logic              w_minor_fire;
    logic [STEP_W-1:0] w_err_nxt;
    logic              w_fire1;
    logic              w_fire2;

    assign w_accept     = (r_state == IDLE) && cmd_valid;
    assign w_zero       = (m1_steps == '0) && (m2_steps == '0);
    assign w_m1_ge      = (m1_steps >= m2_steps);
    assign w_setup_last = (r_setup_cnt == SW'(DIR_SETUP - 1));
    assign w_last_slot  = (r_slots_done == r_n);

    // The timer sits at position 0 outside SLOT, so the SETUP->SLOT edge
    // already sees slot_start and pulse_active.
    assign w_tmr_clr = (r_state != SLOT) || abort;
    assign w_tmr_en  = (r_state == SLOT);

    step_slot_timer #(
        .STEP_PERIOD (STEP_PERIOD),
        .PULSE_W     (PULSE_W)
    ) u_slot_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_tmr_clr),
        .en           (w_tmr_en),
        .slot_start   (w_slot_start),
        .pulse_active (w_pulse_active),
        .slot_end     (w_slot_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = w_zero ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_setup_last) begin
                    w_state_nxt = SLOT;
                end
            end
            SLOT: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_slot_start && w_last_slot) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // err < N always holds, so err + M < 2N fits in STEP_W+1 bits.
    assign w_slot_nxt   = (w_state_nxt == SLOT);
    assign w_new_slot   = w_slot_nxt && w_slot_start;
    assign w_e_sum      = {1'b0, r_err} + {1'b0, r_m};
    assign w_minor_fire = (w_e_sum >= {1'b0, r_n});
    assign w_err_nxt    = w_minor_fire ? STEP_W'(w_e_sum - {1'b0, r_n}) : STEP_W'(w_e_sum);
    assign w_fire1      = w_new_slot ? (r_maj1 || w_minor_fire) : r_fire1;
    assign w_fire2      = w_new_slot ? (!r_maj1 || w_minor_fire) : r_fire2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_step1      <= 1'b0;
            r_step2      <= 1'b0;
            r_dir1       <= 1'b0;
            r_dir2       <= 1'b0;
            r_fire1      <= 1'b0;
            r_fire2      <= 1'b0;
            r_maj1       <= 1'b0;
            r_err        <= '0;
            r_slots_done <= '0;
            r_setup_cnt  <= '0;
        end else begin
            r_ready <= (w_state_nxt == IDLE);
            r_done  <= (w_state_nxt == DONE);
            r_step1 <= w_slot_nxt && w_fire1 && w_pulse_active;
            r_step2 <= w_slot_nxt && w_fire2 && w_pulse_active;
            if (w_accept) begin
                r_dir1       <= dir1_in;
                r_dir2       <= dir2_in;
                r_maj1       <= w_m1_ge;
                r_err        <= '0;
                r_slots_done <= '0;
                r_setup_cnt  <= '0;
            end else begin
                if (r_state == SETUP) begin
                    r_setup_cnt <= r_setup_cnt + 1'b1;
                end
                if (w_slot_nxt && w_slot_end) begin
                    r_slots_done <= r_slots_done + 1'b1;
                end
                if (w_new_slot) begin
                    r_fire1 <= w_fire1;
                    r_fire2 <= w_fire2;
                    r_err   <= w_err_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_n <= w_m1_ge ? m1_steps : m2_steps;
            r_m <= w_m1_ge ? m2_steps : m1_steps;
        end
    end

    assign stepper_ready = r_ready;
    assign step1         = r_step1;
    assign step2         = r_step2;
    assign dir1          = r_dir1;
    assign dir2          = r_dir2;
    assign move_done     = r_done;

endmodule

// File: tb/tb_stepper_scheduler.sv
// Scoreboard bench for stepper_scheduler: stimulus queues expected pin edges,
// done pulses and state samples; a negedge monitor pops and compares them.
module tb_stepper_scheduler;

    localparam int STEP_W = 64;
    localparam int SP     = 10;
    localparam int PW     = 3;
    localparam int DS     = 2;

    localparam int ID_READY = 0;
    localparam int ID_DIR1  = 1;
    localparam int ID_DIR2  = 2;
    localparam int ID_STEP1 = 3;
    localparam int ID_STEP2 = 4;
    localparam int ID_DONE  = 5;
    localparam int ID_EMPTY = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              abort = 1'b0;
    logic              dir1_in = 1'b0;
    logic              dir2_in = 1'b0;
    logic [STEP_W-1:0] m1_steps = '0;
    logic [STEP_W-1:0] m2_steps = '0;
    logic              stepper_ready;
    logic              step1;
    logic              step2;
    logic              dir1;
    logic              dir2;
    logic              move_done;

    stepper_scheduler #(
        .STEP_W      (STEP_W),
        .STEP_PERIOD (SP),
        .PULSE_W     (PW),
        .DIR_SETUP   (DS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .m1_steps      (m1_steps),
        .m2_steps      (m2_steps),
        .dir1_in       (dir1_in),
        .dir2_in       (dir2_in),
        .abort         (abort),
        .stepper_ready (stepper_ready),
        .step1         (step1),
        .step2         (step2),
        .dir1          (dir1),
        .dir2          (dir2),
        .move_done     (move_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        int   id;
        logic val;
    } chk_t;

    chk_t chkq[$];
    int   q_s1[$];
    int   q_s2[$];
    int   q_done[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    int   exp_c;
    logic act;

    // Monitor: compares pin edges and done pulses against queued cycles, and
    // state samples against queued (cycle, signal, value) entries.
    always @(negedge clk) begin
        if (mon_en) begin
            if (step1 != prev1) begin
                total++;
                if (q_s1.size() == 0) begin
                    bad++;
                    $display("FAIL step1_edge got edge at cycle %0d want no edge", cyc);
                end else begin
                    exp_c = q_s1.pop_front();
                    if (exp_c != cyc) begin
                        bad++;
                        $display("FAIL step1_edge got cycle %0d want cycle %0d", cyc, exp_c);
                    end
                end
            end
            if (step2 != prev2) begin
                total++;
                if (q_s2.size() == 0) begin
                    bad++;
                    $display("FAIL step2_edge got edge at cycle %0d want no edge", cyc);
                end else begin
                    exp_c = q_s2.pop_front();
                    if (exp_c != cyc) begin
                        bad++;
                        $display("FAIL step2_edge got cycle %0d want cycle %0d", cyc, exp_c);
                    end
                end
            end
            if (move_done) begin
                total++;
                if (q_done.size() == 0) begin
                    bad++;
                    $display("FAIL move_done got pulse at cycle %0d want no pulse", cyc);
                end else begin
                    exp_c = q_done.pop_front();
                    if (exp_c != cyc) begin
                        bad++;
                        $display("FAIL move_done got cycle %0d want cycle %0d", cyc, exp_c);
                    end
                end
            end
            for (int i = chkq.size() - 1; i >= 0; i--) begin
                if (chkq[i].cyc == cyc) begin
                    case (chkq[i].id)
                        ID_READY: act = stepper_ready;
                        ID_DIR1:  act = dir1;
                        ID_DIR2:  act = dir2;
                        ID_STEP1: act = step1;
                        ID_STEP2: act = step2;
                        ID_DONE:  act = move_done;
                        default:  act = (q_s1.size() == 0) && (q_s2.size() == 0) && (q_done.size() == 0);
                    endcase
                    total++;
                    if (act !== chkq[i].val) begin
                        bad++;
                        $display("FAIL state_id%0d at cycle %0d got %0b want %0b",
                                 chkq[i].id, cyc, act, chkq[i].val);
                    end
                    chkq.delete(i);
                end
            end
        end
        prev1 = step1;
        prev2 = step2;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic want(input int c, input int id, input logic v);
        chk_t t;
        t.cyc = c;
        t.id  = id;
        t.val = v;
        chkq.push_back(t);
    endtask

    task automatic pulse(input int which, input int rise_c, input int fall_c);
        if (which == 1) begin
            q_s1.push_back(rise_c);
            q_s1.push_back(fall_c);
        end else begin
            q_s2.push_back(rise_c);
            q_s2.push_back(fall_c);
        end
    endtask

    task automatic issue(input logic [STEP_W-1:0] a, input logic [STEP_W-1:0] b,
                         input logic d1, input logic d2);
        m1_steps  = a;
        m2_steps  = b;
        dir1_in   = d1;
        dir2_in   = d2;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    int k;
    int k2;

    initial begin
        // Reset values
        tick(3);
        want(cyc + 1, ID_READY, 1'b1);
        want(cyc + 1, ID_STEP1, 1'b0);
        want(cyc + 1, ID_STEP2, 1'b0);
        want(cyc + 1, ID_DIR1, 1'b0);
        want(cyc + 1, ID_DIR2, 1'b0);
        want(cyc + 1, ID_DONE, 1'b0);
        mon_en = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);

        // Basic move 4/2
        k = cyc;
        pulse(1, k + 3, k + 6);
        pulse(1, k + 13, k + 16);
        pulse(1, k + 23, k + 26);
        pulse(1, k + 33, k + 36);
        pulse(2, k + 13, k + 16);
        pulse(2, k + 33, k + 36);
        q_done.push_back(k + 43);
        want(k + 1, ID_DIR1, 1'b1);
        want(k + 1, ID_DIR2, 1'b0);
        want(k + 1, ID_READY, 1'b0);
        want(k + 2, ID_STEP1, 1'b0);
        want(k + 43, ID_READY, 1'b0);
        want(k + 44, ID_READY, 1'b1);
        want(k + 45, ID_EMPTY, 1'b1);
        issue(64'd4, 64'd2, 1'b1, 1'b0);
        wait_until(k + 46);

        // Tie 3/3
        k = cyc;
        pulse(1, k + 3, k + 6);
        pulse(1, k + 13, k + 16);
        pulse(1, k + 23, k + 26);
        pulse(2, k + 3, k + 6);
        pulse(2, k + 13, k + 16);
        pulse(2, k + 23, k + 26);
        q_done.push_back(k + 33);
        want(k + 34, ID_READY, 1'b1);
        want(k + 35, ID_EMPTY, 1'b1);
        issue(64'd3, 64'd3, 1'b0, 1'b0);
        wait_until(k + 36);

        // Joint 2 major 0/5
        k = cyc;
        for (int i = 0; i < 5; i++) pulse(2, k + 3 + 10 * i, k + 6 + 10 * i);
        q_done.push_back(k + 53);
        want(k + 1, ID_DIR1, 1'b0);
        want(k + 1, ID_DIR2, 1'b1);
        want(k + 3, ID_STEP1, 1'b0);
        want(k + 54, ID_READY, 1'b1);
        want(k + 55, ID_EMPTY, 1'b1);
        issue(64'd0, 64'd5, 1'b0, 1'b1);
        wait_until(k + 56);

        // Zero move
        k = cyc;
        q_done.push_back(k + 1);
        want(k + 1, ID_READY, 1'b0);
        want(k + 1, ID_DIR1, 1'b1);
        want(k + 2, ID_READY, 1'b1);
        want(k + 2, ID_DONE, 1'b0);
        want(k + 3, ID_EMPTY, 1'b1);
        issue(64'd0, 64'd0, 1'b1, 1'b1);
        wait_until(k + 4);

        // Abort in cycle 14, with a cmd_valid pulse during SLOT
        k = cyc;
        pulse(1, k + 3, k + 6);
        pulse(1, k + 13, k + 15);
        pulse(2, k + 13, k + 15);
        want(k + 9, ID_READY, 1'b0);
        want(k + 14, ID_READY, 1'b0);
        want(k + 15, ID_READY, 1'b1);
        want(k + 15, ID_STEP1, 1'b0);
        want(k + 16, ID_DIR1, 1'b1);
        want(k + 16, ID_DIR2, 1'b0);
        want(k + 30, ID_EMPTY, 1'b1);
        issue(64'd4, 64'd2, 1'b1, 1'b0);
        wait_until(k + 8);
        m1_steps  = 64'd7;
        m2_steps  = 64'd7;
        dir1_in   = 1'b0;
        dir2_in   = 1'b1;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        wait_until(k + 14);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_until(k + 31);

        // Reset in cycle 20 of a 4/2 move, then a fresh 2/1 move
        k = cyc;
        pulse(1, k + 3, k + 6);
        pulse(1, k + 13, k + 16);
        pulse(2, k + 13, k + 16);
        want(k + 20, ID_READY, 1'b0);
        want(k + 21, ID_READY, 1'b1);
        want(k + 21, ID_DIR1, 1'b0);
        want(k + 21, ID_DIR2, 1'b0);
        want(k + 21, ID_STEP1, 1'b0);
        want(k + 21, ID_DONE, 1'b0);
        want(k + 24, ID_EMPTY, 1'b1);
        issue(64'd4, 64'd2, 1'b1, 1'b0);
        wait_until(k + 20);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        wait_until(k + 25);
        k2 = cyc;
        pulse(1, k2 + 3, k2 + 6);
        pulse(1, k2 + 13, k2 + 16);
        pulse(2, k2 + 13, k2 + 16);
        q_done.push_back(k2 + 23);
        want(k2 + 1, ID_DIR1, 1'b1);
        want(k2 + 1, ID_DIR2, 1'b1);
        want(k2 + 24, ID_READY, 1'b1);
        want(k2 + 25, ID_EMPTY, 1'b1);
        issue(64'd2, 64'd1, 1'b1, 1'b1);
        wait_until(k2 + 27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
